// File: rtl/hk_gpio_pkg.sv
// Shared offsets, per-bank register set and access helpers for the housekeeping GPIO bank.
// Optional input debounce is built when HK_GPIO_DEBOUNCE_EN is defined.
package hk_gpio_pkg;

  localparam logic [31:0] HK_ID_DEFAULT = 32'h0000_0002;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_DIR      = 8'h04;
  localparam logic [7:0] OFF_OUT      = 8'h08;
  localparam logic [7:0] OFF_IN       = 8'h0C;
  localparam logic [7:0] OFF_RISE     = 8'h10;
  localparam logic [7:0] OFF_FALL     = 8'h14;
  localparam logic [7:0] OFF_STATUS   = 8'h18;
  localparam logic [7:0] OFF_MASK     = 8'h1C;
  localparam logic [7:0] OFF_LED      = 8'h30;
  localparam logic [7:0] OFF_DEBOUNCE = 8'h34;
  localparam logic [7:0] OFF_BANK_N   = 8'h40;

  typedef struct packed {
    logic [31:0] dir;
    logic [31:0] out;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] status;
    logic [31:0] mask;
  } bank_regs_t;

  function automatic logic [31:0] width_mask(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Status is owned by the input block, so it is not updated here.
  function automatic bank_regs_t bank_write(input bank_regs_t r, input logic [7:0] loc,
                                            input logic [31:0] d, input logic [31:0] m);
    bank_regs_t n;
    n = r;
    case (loc)
      OFF_DIR:  n.dir     = d & m;
      OFF_OUT:  n.out     = d & m;
      OFF_RISE: n.rise_en = d & m;
      OFF_FALL: n.fall_en = d & m;
      OFF_MASK: n.mask    = d & m;
      default:  ;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] bank_read(input bank_regs_t v, input logic [31:0] in_v,
                                            input logic [7:0] loc);
    case (loc)
      OFF_DIR:    return v.dir;
      OFF_OUT:    return v.out;
      OFF_IN:     return in_v;
      OFF_RISE:   return v.rise_en;
      OFF_FALL:   return v.fall_en;
      OFF_STATUS: return v.status;
      OFF_MASK:   return v.mask;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/hk_gpio_in.sv
// Per-bank input path: 2-FF synchroniser, optional debounce (HK_GPIO_DEBOUNCE_EN),
// edge detect and sticky write-1-to-clear status.
module hk_gpio_in
  import hk_gpio_pkg::*;
#(
  parameter int unsigned DWE = 8
`ifdef HK_GPIO_DEBOUNCE_EN
  ,
  parameter int unsigned DBW = 16
`endif
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [DWE-1:0] i_pin,
  input  logic [DWE-1:0] i_rise_en,
  input  logic [DWE-1:0] i_fall_en,
  input  logic [DWE-1:0] i_w1c,
  input  logic           i_clr_en,
`ifdef HK_GPIO_DEBOUNCE_EN
  input  logic [DBW-1:0] i_debounce,
`endif
  output logic [DWE-1:0] o_in,
  output logic [DWE-1:0] o_status
);

  logic [DWE-1:0] r_meta, r_sync, r_prev, r_status;
  logic [DWE-1:0] w_filt, w_rise, w_fall, w_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

`ifdef HK_GPIO_DEBOUNCE_EN
  logic [DWE-1:0] r_filt;
  logic [DBW-1:0] r_cnt [DWE];

  // A bit follows the synchronised value only after it has differed for DEBOUNCE+1 cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= '0;
      for (int i = 0; i < int'(DWE); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DWE); i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= i_debounce) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_filt = (i_debounce == '0) ? r_sync : r_filt;
`else
  assign w_filt = r_sync;
`endif

  assign w_rise = w_filt & ~r_prev & i_rise_en;
  assign w_fall = ~w_filt & r_prev & i_fall_en;
  assign w_clr  = i_w1c & {DWE{i_clr_en}};

  // New edges are OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev   <= '0;
      r_status <= '0;
    end else begin
      r_prev   <= w_filt;
      r_status <= (r_status & ~w_clr) | w_rise | w_fall;
    end
  end

  assign o_in     = w_filt;
  assign o_status = r_status;

endmodule

// File: rtl/hk_gpio_bank.sv
// Housekeeping GPIO bank: LED, P/N expansion banks with edge capture and masked interrupt.
// Define HK_GPIO_DEBOUNCE_EN to build the input debounce filter and its register at 0x34.
module hk_gpio_bank
  import hk_gpio_pkg::*;
#(
  parameter int unsigned DWL = 8,
  parameter int unsigned DWE = 8,
  parameter logic [31:0] ID  = HK_ID_DEFAULT,
  parameter int unsigned DBW = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic [DWL-1:0] led_o,
  input  logic [DWE-1:0] exp_p_dat_i,
  output logic [DWE-1:0] exp_p_dat_o,
  output logic [DWE-1:0] exp_p_dir_o,
  input  logic [DWE-1:0] exp_n_dat_i,
  output logic [DWE-1:0] exp_n_dat_o,
  output logic [DWE-1:0] exp_n_dir_o,
  output logic           irq_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic [3:0]     sys_sel,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);

  localparam logic [31:0] EXP_MASK = width_mask(DWE);
  localparam logic [31:0] LED_MASK = width_mask(DWL);

  bank_regs_t     r_p, r_n, w_p, w_n;
  logic [31:0]    r_led, r_rdata, w_rdata, w_deb_rd;
  logic           r_ack, r_irq;
  logic [7:0]     w_off, w_loc;
  logic           w_is_p, w_is_n, w_clr_p, w_clr_n;
  logic [DWE-1:0] w_in_p, w_in_n, w_status_p, w_status_n;
  logic           w_unused;

  assign w_off    = sys_addr[7:0];
  assign w_loc    = {2'b00, sys_addr[5:0]};
  assign w_is_p   = ~sys_addr[7] & ~sys_addr[6];
  assign w_is_n   = ~sys_addr[7] & sys_addr[6];
  assign w_clr_p  = sys_wen & w_is_p & (w_loc == OFF_STATUS);
  assign w_clr_n  = sys_wen & w_is_n & (w_loc == OFF_STATUS);
  assign w_unused = ^{sys_sel, sys_addr[31:8]};

`ifdef HK_GPIO_DEBOUNCE_EN
  logic [DBW-1:0] r_debounce;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_debounce <= '0;
    else if (sys_wen && w_off == OFF_DEBOUNCE) r_debounce <= sys_wdata[DBW-1:0];
  end

  assign w_deb_rd = 32'(r_debounce);
`else
  logic [DBW-1:0] w_unused_dbw;
  assign w_unused_dbw = '0;
  assign w_deb_rd     = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p   <= '0;
      r_n   <= '0;
      r_led <= '0;
    end else if (sys_wen) begin
      if (w_is_p) r_p <= bank_write(r_p, w_loc, sys_wdata, EXP_MASK);
      if (w_is_n) r_n <= bank_write(r_n, w_loc, sys_wdata, EXP_MASK);
      if (w_off == OFF_LED) r_led <= sys_wdata & LED_MASK;
    end
  end

  hk_gpio_in #(
    .DWE(DWE)
`ifdef HK_GPIO_DEBOUNCE_EN
    ,
    .DBW(DBW)
`endif
  ) u_in_p (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_pin     (exp_p_dat_i),
    .i_rise_en (r_p.rise_en[DWE-1:0]),
    .i_fall_en (r_p.fall_en[DWE-1:0]),
    .i_w1c     (sys_wdata[DWE-1:0]),
    .i_clr_en  (w_clr_p),
`ifdef HK_GPIO_DEBOUNCE_EN
    .i_debounce(r_debounce),
`endif
    .o_in      (w_in_p),
    .o_status  (w_status_p)
  );

  hk_gpio_in #(
    .DWE(DWE)
`ifdef HK_GPIO_DEBOUNCE_EN
    ,
    .DBW(DBW)
`endif
  ) u_in_n (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_pin     (exp_n_dat_i),
    .i_rise_en (r_n.rise_en[DWE-1:0]),
    .i_fall_en (r_n.fall_en[DWE-1:0]),
    .i_w1c     (sys_wdata[DWE-1:0]),
    .i_clr_en  (w_clr_n),
`ifdef HK_GPIO_DEBOUNCE_EN
    .i_debounce(r_debounce),
`endif
    .o_in      (w_in_n),
    .o_status  (w_status_n)
  );

  always_comb begin
    w_p                   = r_p;
    w_p.status            = '0;
    w_p.status[DWE-1:0]   = w_status_p;
    w_n                   = r_n;
    w_n.status            = '0;
    w_n.status[DWE-1:0]   = w_status_n;
  end

  always_comb begin
    w_rdata = '0;
    if (w_off == OFF_ID)             w_rdata = ID;
    else if (w_off == OFF_LED)       w_rdata = r_led;
    else if (w_off == OFF_DEBOUNCE)  w_rdata = w_deb_rd;
    else if (w_is_p)                 w_rdata = bank_read(w_p, 32'(w_in_p), w_loc);
    else if (w_is_n)                 w_rdata = bank_read(w_n, 32'(w_in_n), w_loc);
  end

  // Read data comes from pre-write state, so a combined read/write returns the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ack   <= sys_wen | sys_ren;
      r_rdata <= sys_ren ? w_rdata : '0;
      r_irq   <= (|(w_p.status & r_p.mask)) | (|(w_n.status & r_n.mask));
    end
  end

  assign led_o       = r_led[DWL-1:0];
  assign exp_p_dir_o = r_p.dir[DWE-1:0];
  assign exp_p_dat_o = r_p.out[DWE-1:0];
  assign exp_n_dir_o = r_n.dir[DWE-1:0];
  assign exp_n_dat_o = r_n.out[DWE-1:0];
  assign irq_o       = r_irq;
  assign sys_rdata   = r_rdata;
  assign sys_ack     = r_ack;
  assign sys_err     = 1'b0;

endmodule

// File: tb/tb_hk_gpio_bank.sv
// Directed bench for hk_gpio_bank: bus transactions feed a scoreboard checked on sys_ack.
module tb_hk_gpio_bank;

  logic        clk, rst;
  logic [7:0]  led_o;
  logic [7:0]  exp_p_dat_i, exp_p_dat_o, exp_p_dir_o;
  logic [7:0]  exp_n_dat_i, exp_n_dat_o, exp_n_dir_o;
  logic        irq_o;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  typedef struct {
    logic [31:0] data;
    bit          rd;
    string       name;
  } txn_t;

  txn_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ack_exp;

  hk_gpio_bank #(
    .DWL(8),
    .DWE(8),
    .ID (32'h0000_0002),
    .DBW(16)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .led_o      (led_o),
    .exp_p_dat_i(exp_p_dat_i),
    .exp_p_dat_o(exp_p_dat_o),
    .exp_p_dir_o(exp_p_dir_o),
    .exp_n_dat_i(exp_n_dat_i),
    .exp_n_dat_o(exp_n_dat_o),
    .exp_n_dir_o(exp_n_dir_o),
    .irq_o      (irq_o),
    .sys_addr   (sys_addr),
    .sys_wdata  (sys_wdata),
    .sys_sel    (sys_sel),
    .sys_wen    (sys_wen),
    .sys_ren    (sys_ren),
    .sys_rdata  (sys_rdata),
    .sys_err    (sys_err),
    .sys_ack    (sys_ack)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Ack must follow every strobe by exactly one cycle; reset cancels a pending one.
  always @(posedge clk or posedge rst) begin
    if (rst) ack_exp <= 1'b0;
    else     ack_exp <= sys_wen | sys_ren;
  end

  always @(negedge clk) begin
    txn_t t;
    if (sys_ack || ack_exp) check("ack_timing", {31'b0, sys_ack}, {31'b0, ack_exp});
    if (sys_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: got ack with empty queue, required none");
      end else begin
        t = sb_q.pop_front();
        if (t.rd) check(t.name, sys_rdata, t.data);
      end
    end
    if (sys_err) check("sys_err", {31'b0, sys_err}, 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                          input logic re, input logic [31:0] exp, input string name);
    txn_t t;
    @(posedge clk);
    #1;
    sys_addr  = addr;
    sys_wdata = wd;
    sys_wen   = we;
    sys_ren   = re;
    t.data = exp;
    t.rd   = re;
    t.name = name;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
    sys_wen = 1'b0;
    sys_ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    bus_xfer(addr, 1'b1, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus_xfer(addr, 1'b0, 32'd0, 1'b1, exp, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    exp_p_dat_i = 8'h00;
    exp_n_dat_i = 8'h80;
    sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;

    tick(3);
    check("rst_led", {24'b0, led_o}, 32'h0);
    check("rst_p_dir", {24'b0, exp_p_dir_o}, 32'h0);
    check("rst_p_dat", {24'b0, exp_p_dat_o}, 32'h0);
    check("rst_n_dir", {24'b0, exp_n_dir_o}, 32'h0);
    check("rst_n_dat", {24'b0, exp_n_dat_o}, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    check("rst_ack", {31'b0, sys_ack}, 32'h0);
    check("rst_rdata", sys_rdata, 32'h0);
    rst = 1'b0;
    tick(4);

    rd(32'h00, 32'h0000_0002, "id");
    rd(32'h100, 32'h0000_0002, "id_alias");

    wr(32'h30, 32'hAA);
    check("led_aa", {24'b0, led_o}, 32'hAA);
    wr(32'h04, 32'hFFFF_FF33);
    wr(32'h08, 32'h0F);
    check("p_dir", {24'b0, exp_p_dir_o}, 32'h33);
    check("p_dat", {24'b0, exp_p_dat_o}, 32'h0F);
    rd(32'h04, 32'h33, "rd_dir_p");
    rd(32'h08, 32'h0F, "rd_out_p");
    wr(32'h44, 32'hC0);
    wr(32'h48, 32'h5A);
    check("n_dir", {24'b0, exp_n_dir_o}, 32'hC0);
    check("n_dat", {24'b0, exp_n_dat_o}, 32'h5A);

    bus_xfer(32'h30, 1'b1, 32'h55, 1'b1, 32'hAA, "rw_led_old");
    check("led_55", {24'b0, led_o}, 32'h55);
    rd(32'h30, 32'h55, "rd_led");

    wr(32'h20, 32'hFFFF_FFFF);
    rd(32'h20, 32'h0, "unmapped_20");
    rd(32'h80, 32'h0, "unmapped_80");
    rd(32'h70, 32'h0, "unmapped_70");
`ifndef HK_GPIO_DEBOUNCE_EN
    wr(32'h34, 32'h7);
    rd(32'h34, 32'h0, "debounce_absent");
`endif
    rd(32'h0C, 32'h00, "in_p");
    rd(32'h4C, 32'h80, "in_n");

    // Rising edge on P0, which is configured as an output (loopback sampling).
    wr(32'h10, 32'h01);
    wr(32'h1C, 32'h01);
    exp_p_dat_i[0] = 1'b1;
    tick(2);
    check("irq_k2", {31'b0, irq_o}, 32'h0);
    tick(1);
    check("irq_k3", {31'b0, irq_o}, 32'h0);
    tick(1);
    check("irq_k4", {31'b0, irq_o}, 32'h1);
    rd(32'h18, 32'h01, "status_p_set");
    rd(32'h0C, 32'h01, "in_p_hi");
    wr(32'h18, 32'h01);
    check("irq_clr_hold", {31'b0, irq_o}, 32'h1);
    tick(1);
    check("irq_clr", {31'b0, irq_o}, 32'h0);
    rd(32'h18, 32'h00, "status_p_clr");

    // Edge lands on the same edge as the W1C of that bit.
    exp_p_dat_i[0] = 1'b0;
    tick(4);
    exp_p_dat_i[0] = 1'b1;
    tick(1);
    wr(32'h18, 32'h01);
    tick(1);
    check("irq_set_wins", {31'b0, irq_o}, 32'h1);
    rd(32'h18, 32'h01, "status_set_wins");
    wr(32'h18, 32'h01);
    tick(1);
    check("irq_clr2", {31'b0, irq_o}, 32'h0);

    // Falling edge on N7 captured while masked, then unmasked.
    wr(32'h54, 32'h80);
    exp_n_dat_i[7] = 1'b0;
    tick(5);
    rd(32'h58, 32'h80, "status_n_fall");
    check("irq_masked", {31'b0, irq_o}, 32'h0);
    wr(32'h5C, 32'h80);
    check("irq_unmask_hold", {31'b0, irq_o}, 32'h0);
    tick(1);
    check("irq_unmasked", {31'b0, irq_o}, 32'h1);
    rd(32'h5C, 32'h80, "rd_mask_n");
    wr(32'h5C, 32'h00);
    tick(1);
    check("irq_remasked", {31'b0, irq_o}, 32'h0);

    // Reset lands between a read strobe and its ack.
    @(posedge clk);
    #1;
    sys_addr = 32'h0;
    sys_ren  = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sys_ren = 1'b0;
    tick(2);
    check("ack_dropped", {31'b0, sys_ack}, 32'h0);
    check("rst2_led", {24'b0, led_o}, 32'h0);
    check("rst2_n_dir", {24'b0, exp_n_dir_o}, 32'h0);
    exp_p_dat_i = 8'h00;
    rst = 1'b0;
    tick(4);
    check("no_late_ack", {31'b0, sys_ack}, 32'h0);
    rd(32'h00, 32'h0000_0002, "id_after_rst");
    rd(32'h58, 32'h00, "status_n_rst");

`ifdef HK_GPIO_DEBOUNCE_EN
    wr(32'h10, 32'h04);
    wr(32'h34, 32'd10);
    rd(32'h34, 32'd10, "rd_debounce");
    exp_p_dat_i[2] = 1'b1;
    tick(5);
    exp_p_dat_i[2] = 1'b0;
    tick(20);
    rd(32'h0C, 32'h00, "in_glitch");
    rd(32'h18, 32'h00, "status_glitch");
    exp_p_dat_i[2] = 1'b1;
    tick(30);
    rd(32'h0C, 32'h04, "in_steady");
    rd(32'h18, 32'h04, "status_steady");
`endif

    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() != 0) @(posedge clk);
    end
    tick(2);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
